// File: rtl/pipo_pkg.sv
`timescale 1ns/1ps
// Shared types and helpers for the PIPO round-robin write arbiter.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package pipo_pkg;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  localparam int N_DEF         = 4;
  localparam int W_DEF         = 8;
  localparam int MAX_BURST_DEF = 4;
  localparam int N_MAX         = 8;

  // Result of a round-robin search: winner index and whether any request was seen.
  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // One-hot vector of width N_MAX; callers cast down to their own N.
  function automatic logic [N_MAX-1:0] onehot(input logic [2:0] idx, input int n);
    logic [N_MAX-1:0] v;
    v = '0;
    if (int'(idx) < n) v[idx] = 1'b1;
    return v;
  endfunction

  // First set request at or after ptr, wrapping modulo n.
  function automatic pick_t rr_pick(input logic [N_MAX-1:0] req, input logic [2:0] ptr,
                                    input int n);
    pick_t p;
    int    j;
    p = '0;
    for (int i = 0; i < N_MAX; i++) begin
      if (i < n && !p.found) begin
        j = (int'(ptr) + i) % n;
        if (req[3'(j)]) begin
          p.found = 1'b1;
          p.idx   = 3'(j);
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/pipo_reg.sv
`timescale 1ns/1ps
// W-bit parallel-in/parallel-out register with load enable.
// Latency: d appears on q one rising edge after ld is sampled high.
// Backpressure: none; holds its value whenever ld is low.
// Ports: q (stored word), d (load data), CLK, n_res (async active-low), ld (load enable).
module pipo_reg #(
  parameter int W = 8
) (
  output logic [W-1:0] q,
  input  logic [W-1:0] d,
  input  logic         CLK,
  input  logic         n_res,
  input  logic         ld
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (ld) q_d = d;
  end

  always_ff @(posedge CLK or negedge n_res) begin
    if (!n_res) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/pipo_arbiter.sv
`timescale 1ns/1ps
// Round-robin write arbiter for a shared PIPO register, with bounded owner bursts.
// Latency: request sampled at edge k loads q and raises ack at the same edge k (one cycle).
// Backpressure: losers simply keep req high; a burst ends with one dead (no-load) cycle.
// Ports: CLK, n_res (async active-low); req/lock/din per requester; q (register),
//        ack (one-hot load strobe), valid (loaded since reset), busy (burst active), owner.
module pipo_arbiter
  import pipo_pkg::*;
#(
  parameter  int N         = N_DEF,
  parameter  int W         = W_DEF,
  parameter  int MAX_BURST = MAX_BURST_DEF,
  localparam int PW        = $clog2(N)
) (
  input  logic           CLK,
  input  logic           n_res,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   lock,
  input  logic [N*W-1:0] din,
  output logic [W-1:0]   q,
  output logic [N-1:0]   ack,
  output logic           valid,
  output logic           busy,
  output logic [PW-1:0]  owner
);

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [N-1:0]  ack_q, ack_d;
  logic          valid_q, valid_d;
  logic          ld;
  logic [W-1:0]  ld_dat;
  logic [PW-1:0] win;
  pick_t         pick;
  logic [W-1:0]  din_a [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign din_a[i] = din[i*W +: W];
  end

  // State register
  always_ff @(posedge CLK or negedge n_res) begin
    if (!n_res) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
    end
  end

  // Next-state and load control
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    valid_d = valid_q;
    ld      = 1'b0;
    ld_dat  = '0;
    pick    = rr_pick(N_MAX'(req), 3'(ptr_q), N);
    win     = PW'(pick.idx);
    unique case (state_q)
      IDLE: begin
        if (pick.found) begin
          ld      = 1'b1;
          ld_dat  = din_a[win];
          ack_d   = N'(onehot(pick.idx, N));
          owner_d = win;
          valid_d = 1'b1;
          // Winner drops to lowest priority for the next arbitration.
          ptr_d   = PW'((int'(pick.idx) + 1) % N);
          cnt_d   = 4'd1;
          if (lock[win] && MAX_BURST > 1) state_d = BURST;
        end
      end
      BURST: begin
        // The load that brings cnt to MAX_BURST stays in BURST; the following
        // edge fails the cnt check and becomes the dead release cycle.
        if (req[owner_q] && lock[owner_q] && cnt_q < MAX_B) begin
          ld     = 1'b1;
          ld_dat = din_a[owner_q];
          ack_d  = N'(onehot(3'(owner_q), N));
          cnt_d  = cnt_q + 4'd1;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy  = (state_q == BURST);
    ack   = ack_q;
    valid = valid_q;
    owner = owner_q;
  end

  pipo_reg #(.W(W)) u_reg (
    .q     (q),
    .d     (ld_dat),
    .CLK   (CLK),
    .n_res (n_res),
    .ld    (ld)
  );

endmodule

// File: tb/tb_pipo_arbiter.sv
`timescale 1ns/1ps
module tb_pipo_arbiter;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int MAXB = 4;

  logic         CLK;
  logic         n_res;
  logic [N-1:0] req;
  logic [N-1:0] lock;
  logic [N*W-1:0] din;
  logic [W-1:0] q;
  logic [N-1:0] ack;
  logic         valid;
  logic         busy;
  logic [1:0]   owner;

  pipo_arbiter #(.N(N), .W(W), .MAX_BURST(MAXB)) dut (
    .CLK   (CLK),
    .n_res (n_res),
    .req   (req),
    .lock  (lock),
    .din   (din),
    .q     (q),
    .ack   (ack),
    .valid (valid),
    .busy  (busy),
    .owner (owner)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit bit_of(input logic [N-1:0] v, input int i);
    return ((v >> i) & 4'd1) != 4'd0;
  endfunction

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [7:0] dat;
    logic [3:0] ack;
    int         who;
  } exp_t;

  exp_t       exp_q[$];
  int         m_ptr   = 0;
  int         m_owner = 0;
  int         m_loads = 0;
  bit         m_burst = 0;
  bit         m_valid = 0;
  logic [7:0] m_q     = '0;

  task automatic model_load(input int w);
    exp_t e;
    e.dat   = 8'(din >> (w * W));
    e.ack   = 4'(1 << w);
    e.who   = w;
    exp_q.push_back(e);
    m_q     = e.dat;
    m_owner = w;
    m_valid = 1'b1;
  endtask

  always @(posedge CLK or negedge n_res) begin
    if (!n_res) begin
      m_ptr = 0; m_owner = 0; m_loads = 0; m_burst = 0; m_valid = 0; m_q = '0;
      exp_q.delete();
    end else if (!m_burst) begin : arb
      int w;
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && bit_of(req, (m_ptr + k) % N)) w = (m_ptr + k) % N;
      if (w >= 0) begin
        model_load(w);
        m_ptr   = (w + 1) % N;
        m_loads = 1;
        m_burst = bit_of(lock, w) && (MAXB > 1);
      end
    end else if (bit_of(req, m_owner) && bit_of(lock, m_owner) && m_loads < MAXB) begin
      model_load(m_owner);
      m_loads++;
    end else begin
      m_burst = 1'b0;  // dead release cycle
    end
  end

  // Monitor: compares DUT outputs against the scoreboard after each edge.
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (n_res) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("load_ack", 32'(ack), 32'(e.ack));
        check("load_q", 32'(q), 32'(e.dat));
        check("load_owner", 32'(owner), 32'(e.who));
      end else begin
        check("idle_ack", 32'(ack), 32'd0);
        check("hold_q", 32'(q), 32'(m_q));
        check("hold_owner", 32'(owner), 32'(m_owner));
      end
      check("busy", 32'(busy), 32'(m_burst));
      check("valid", 32'(valid), 32'(m_valid));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic [31:0] d);
    @(negedge CLK);
    req  = r;
    lock = l;
    din  = d;
  endtask

  task automatic mid_reset_pulse(input string tag);
    @(posedge CLK);
    #3;
    n_res = 1'b0;
    #0.001;
    check({tag, "_q"}, 32'(q), 32'd0);
    check({tag, "_ack"}, 32'(ack), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    #0.014;
    n_res = 1'b1;
  endtask

  localparam logic [31:0] D_INC = 32'h13121110;

  initial begin
    n_res = 1'b0;
    req   = 4'b1111;
    lock  = 4'b0000;
    din   = D_INC;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_q", 32'(q), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    @(negedge CLK);
    n_res = 1'b1;

    // 1: all requesting, rotation 0,1,2,3,0
    repeat (4) drive(4'b1111, 4'b0000, D_INC);
    drive(4'b0000, 4'b0000, D_INC);

    // 2: single one-cycle pulse on requester 2
    drive(4'b0100, 4'b0000, 32'h00A50000);
    drive(4'b0000, 4'b0000, 32'h00A50000);

    // 3: requester 1 bursts 01..04, requester 3 waits, dead cycle, then 3
    drive(4'b0010, 4'b0010, 32'h00000100);
    drive(4'b1010, 4'b0010, 32'h33000200);
    drive(4'b1010, 4'b0010, 32'h33000300);
    drive(4'b1010, 4'b0010, 32'h33000400);
    drive(4'b1010, 4'b0010, 32'h33000500);
    drive(4'b1010, 4'b0010, 32'h33000500);
    drive(4'b0000, 4'b0000, 32'h0);

    // 4: requester 0 burst released after two loads, then requester 2
    drive(4'b0101, 4'b0001, 32'h00420040);
    drive(4'b0101, 4'b0001, 32'h00420041);
    drive(4'b0100, 4'b0000, 32'h00420041);
    drive(4'b0100, 4'b0000, 32'h00420041);
    drive(4'b0000, 4'b0000, 32'h0);

    // 5: wrap-around with ptr at 3
    drive(4'b1001, 4'b0000, 32'hD3000050);
    drive(4'b1001, 4'b0000, 32'hD3000050);
    drive(4'b0000, 4'b0000, 32'h0);

    // 6: async reset mid-burst, then arbitration restarts from 0
    drive(4'b0010, 4'b0010, 32'h00007700);
    drive(4'b0010, 4'b0010, 32'h00007800);
    mid_reset_pulse("arst");
    drive(4'b0011, 4'b0000, 32'h00008180);
    drive(4'b0011, 4'b0000, 32'h00008180);
    drive(4'b0000, 4'b0000, 32'h0);

    // Random traffic with occasional reset pulses
    for (int i = 0; i < 800; i++) begin
      drive(4'($urandom), 4'($urandom), $urandom);
      if ($urandom_range(0, 99) == 0) mid_reset_pulse("rnd_arst");
    end
    drive(4'b0000, 4'b0000, 32'h0);
    repeat (3) @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
